ifm_row_buffer: RTL and testbench
=================================

IFM_ROW_BUFFER -- requirements
Module: ifm_row_buffer

Interface
REQ-001 Parameter IFM_DW, default 32: width of one IFM word (packed channels of one pixel).
REQ-002 Parameter W_SIZE, default 9: width of width, height, row and column fields.
REQ-003 Parameter BUF_DEPTH, default 256: words per row bank, which is the maximum q_width.
REQ-004 Parameter BUF_AW, default 8: bank address width (log2 BUF_DEPTH).
REQ-005 clk  in  1  the single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 q_width  in  W_SIZE  frame width in pixels.
REQ-008 q_height  in  W_SIZE  frame height in rows.
REQ-009 q_start  in  1  frame start pulse; clears residency, bank pointer and error.
REQ-010 c_ifm_buf_req_load  in  1  single-cycle row-load request from cnn_ctrl.
REQ-011 c_ifm_buf_req_row  in  W_SIZE  row index for the load request.
REQ-012 o_dma_req  out  1  single-cycle pulse asking the DMA to stream row o_dma_row.
REQ-013 o_dma_row  out  W_SIZE  row index being fetched.
REQ-014 dma_valid  in  1  DMA data valid.
REQ-015 dma_data  in  IFM_DW  DMA data word.
REQ-016 o_dma_ready  out  1  the block accepts a DMA word this cycle.
REQ-017 o_ifm_buf_done  out  1  single-cycle pulse: requested row is fully resident.
REQ-018 o_busy  out  1  high in any FSM state other than IDLE.
REQ-019 c_ctrl_data_run  in  1  PE data phase is active.
REQ-020 c_row, c_col  in  W_SIZE each  current output pixel position.
REQ-021 o_ib_data0, o_ib_data1, o_ib_data2  out  IFM_DW each  rows c_row-1, c_row and c_row+1 at column c_col; these feed pe_engine ib_data0/1/2_in.
REQ-022 o_ib_valid  out  1  the o_ib_data outputs are valid.
REQ-023 o_err  out  1  sticky protocol-error flag.

Function
REQ-024 Storage SHALL be three banks of BUF_DEPTH x IFM_DW, each with a valid bit and a W_SIZE row tag.
REQ-025 The FSM SHALL have states IDLE, REQ, FILL and DONE.
REQ-026 IDLE: a load pulse SHALL latch the row, select bank = bank pointer, clear that bank's valid bit and go to REQ.
REQ-027 REQ: o_dma_req=1 and o_dma_row=latched row for exactly one cycle, then go to FILL with column counter=0.
REQ-028 FILL: o_dma_ready=1; each cycle with dma_valid&&o_dma_ready SHALL write dma_data to bank[col] and increment col.
REQ-029 FILL SHALL go to DONE when the q_width-th word is accepted. If q_width=0, REQ SHALL go directly to DONE.
REQ-030 DONE: for one cycle, o_ifm_buf_done=1, tag=row, valid=1, bank pointer advances 0->1->2->0; then return to IDLE.
REQ-031 A load pulse received outside IDLE SHALL be ignored and SHALL set o_err.
REQ-032 Read: while c_ctrl_data_run=1, each of the three rows SHALL be looked up by tag match among the valid banks and read at c_col.
REQ-033 Read latency SHALL be 1 cycle; o_ib_valid = c_ctrl_data_run delayed by 1 cycle.
REQ-034 Padding: o_ib_data0=0 when c_row=0; o_ib_data2=0 when c_row=q_height-1.
REQ-035 When q_height=1, both o_ib_data0 and o_ib_data2 SHALL be zero.
REQ-036 A needed row with no resident bank SHALL output 0 and set o_err. A row in the bank being filled is not resident.
REQ-037 A read and a fill of different banks SHALL proceed in the same cycle without interference.
REQ-038 q_start in any state SHALL abort any fill, clear all valid bits, set bank pointer=0, clear o_err and go to IDLE; a load pulse in the same cycle is dropped.
REQ-039 When the FSM is not in FILL, o_dma_ready=0 and DMA words SHALL be discarded.

Reset
REQ-040 On rst: FSM=IDLE, all valid bits=0, bank pointer=0, col=0, all outputs=0; bank contents are not cleared.
REQ-041 rst asserted mid-FILL SHALL abandon the row; that bank stays invalid.

Structure
REQ-042 IFM_DW, W_SIZE, BUF_AW and the FSM state encoding SHALL be defined in the shared controller_params package.
REQ-043 The bank SHALL be one sub-module, ifm_bank_ram (1 write port, 1 synchronous read port), instantiated 3 times.

Verification
REQ-044 W=16, H=3: load rows 0,1,2 with 16 words each (row0[0]=32'h00707064) -> three o_ifm_buf_done pulses, each 1 cycle after the 16th word, banks 0,1,2 used.
REQ-045 data_run with c_row=0, c_col=0 -> 1 cycle later data0=0, data1=32'h00707064, data2=row1[0]=32'h00474644, o_ib_valid=1.
REQ-046 c_row=2, c_col=15 -> data0=32'h003A3B39, data1=32'h00404040, data2=0.
REQ-047 Second load pulse during FILL -> ignored, o_err=1, the first fill completes normally.
REQ-048 Load row 3 after rows 0-2 -> bank 0 overwritten; a read of row 0 returns 0 and sets o_err.
REQ-049 rst after 5 FILL words, then reload -> fresh fill from col=0, o_ifm_buf_done only after 16 new words.

Source files
------------

// File: rtl/controller_params.sv
// Shared CNN controller parameters, FSM encodings and small helpers.
package controller_params;

    localparam int IFM_DW    = 32;
    localparam int W_SIZE    = 9;
    localparam int BUF_DEPTH = 256;
    localparam int BUF_AW    = 8;
    localparam int NBANK     = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } ifm_state_t;

    // Round-robin over the three row banks.
    function automatic logic [1:0] next_bank(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

endpackage

// File: rtl/ifm_bank_ram.sv
// One row bank: single write port, single synchronous read port.
module ifm_bank_ram #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ifm_row_buffer.sv
// Three-bank IFM row cache: DMA row fill FSM plus 3-row tagged read for the PE array.
module ifm_row_buffer #(
    parameter int IFM_DW    = controller_params::IFM_DW,
    parameter int W_SIZE    = controller_params::W_SIZE,
    parameter int BUF_DEPTH = controller_params::BUF_DEPTH,
    parameter int BUF_AW    = controller_params::BUF_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_SIZE-1:0] q_width,
    input  logic [W_SIZE-1:0] q_height,
    input  logic              q_start,
    input  logic              c_ifm_buf_req_load,
    input  logic [W_SIZE-1:0] c_ifm_buf_req_row,
    output logic              o_dma_req,
    output logic [W_SIZE-1:0] o_dma_row,
    input  logic              dma_valid,
    input  logic [IFM_DW-1:0] dma_data,
    output logic              o_dma_ready,
    output logic              o_ifm_buf_done,
    output logic              o_busy,
    input  logic              c_ctrl_data_run,
    input  logic [W_SIZE-1:0] c_row,
    input  logic [W_SIZE-1:0] c_col,
    output logic [IFM_DW-1:0] o_ib_data0,
    output logic [IFM_DW-1:0] o_ib_data1,
    output logic [IFM_DW-1:0] o_ib_data2,
    output logic              o_ib_valid,
    output logic              o_err
);

    import controller_params::*;

    ifm_state_t        state, state_n;
    logic [W_SIZE-1:0] row_q;
    logic [W_SIZE-1:0] col;
    logic [1:0]        bank_sel;
    logic [1:0]        bank_ptr;
    logic [2:0]        valid;
    logic [W_SIZE-1:0] tag [3];
    logic              err;
    logic              fill_we;
    logic              last_word;

    logic [IFM_DW-1:0] rdata [3];
    logic [W_SIZE-1:0] rd_row [3];
    logic [2:0]        hit, pad;
    logic [1:0]        hit_idx [3];
    logic              rd_miss;
    logic [1:0]        sel_q [3];
    logic [2:0]        zero_q;
    logic              ib_valid_q;
    logic              unused_col;

    assign unused_col = ^c_col[W_SIZE-1:BUF_AW];
    assign fill_we    = (state == S_FILL) && dma_valid;
    assign last_word  = (col + W_SIZE'(1)) == q_width;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (c_ifm_buf_req_load) state_n = S_REQ;
            S_REQ:  state_n = (q_width == '0) ? S_DONE : S_FILL;
            S_FILL: if (fill_we && last_word) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (q_start)
            state_n = S_IDLE;
    end

    always_comb begin
        o_dma_req      = 1'b0;
        o_dma_ready    = 1'b0;
        o_ifm_buf_done = 1'b0;
        o_busy         = (state != S_IDLE);
        unique case (state)
            S_REQ:   o_dma_req      = 1'b1;
            S_FILL:  o_dma_ready    = 1'b1;
            S_DONE:  o_ifm_buf_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            col      <= '0;
            bank_sel <= '0;
            bank_ptr <= '0;
            valid    <= '0;
            err      <= 1'b0;
            for (int b = 0; b < 3; b++)
                tag[b] <= '0;
        end else begin
            if (state == S_IDLE && c_ifm_buf_req_load) begin
                row_q           <= c_ifm_buf_req_row;
                bank_sel        <= bank_ptr;
                valid[bank_ptr] <= 1'b0;
            end
            if (state != S_IDLE && c_ifm_buf_req_load)
                err <= 1'b1;
            if (state == S_REQ)
                col <= '0;
            if (fill_we)
                col <= col + W_SIZE'(1);
            if (state == S_DONE) begin
                tag[bank_sel]   <= row_q;
                valid[bank_sel] <= 1'b1;
                bank_ptr        <= next_bank(bank_ptr);
            end
            if (rd_miss)
                err <= 1'b1;
            // Frame start wins over everything above, including a same-cycle load.
            if (q_start) begin
                valid    <= '0;
                bank_ptr <= '0;
                col      <= '0;
                err      <= 1'b0;
            end
        end
    end

    assign o_dma_row = row_q;
    assign o_err     = err;

    for (genvar b = 0; b < 3; b++) begin : g_bank
        ifm_bank_ram #(
            .DW    (IFM_DW),
            .AW    (BUF_AW),
            .DEPTH (BUF_DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (fill_we && bank_sel == 2'(b)),
            .waddr (col[BUF_AW-1:0]),
            .wdata (dma_data),
            .raddr (c_col[BUF_AW-1:0]),
            .rdata (rdata[b])
        );
    end

    assign rd_row[0] = c_row - W_SIZE'(1);
    assign rd_row[1] = c_row;
    assign rd_row[2] = c_row + W_SIZE'(1);

    // The bank under fill has its valid bit cleared, so it never matches here.
    always_comb begin
        hit = '0;
        pad = '0;
        for (int r = 0; r < 3; r++) begin
            hit_idx[r] = '0;
            for (int b = 0; b < 3; b++) begin
                if (!hit[r] && valid[b] && tag[b] == rd_row[r]) begin
                    hit[r]     = 1'b1;
                    hit_idx[r] = 2'(b);
                end
            end
        end
        pad[0]  = (c_row == '0);
        pad[2]  = (c_row == q_height - W_SIZE'(1));
        rd_miss = c_ctrl_data_run && |(~pad & ~hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q     <= '1;
            ib_valid_q <= 1'b0;
            for (int r = 0; r < 3; r++)
                sel_q[r] <= '0;
        end else begin
            ib_valid_q <= c_ctrl_data_run;
            for (int r = 0; r < 3; r++) begin
                sel_q[r]  <= hit_idx[r];
                zero_q[r] <= !c_ctrl_data_run || pad[r] || !hit[r];
            end
        end
    end

    assign o_ib_data0 = zero_q[0] ? '0 : rdata[sel_q[0]];
    assign o_ib_data1 = zero_q[1] ? '0 : rdata[sel_q[1]];
    assign o_ib_data2 = zero_q[2] ? '0 : rdata[sel_q[2]];
    assign o_ib_valid = ib_valid_q;

endmodule

// File: tb/tb_ifm_row_buffer.sv
// Randomized self-checking bench for ifm_row_buffer against a row-residency model.
module tb_ifm_row_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  q_width, q_height;
    logic        q_start;
    logic        c_ifm_buf_req_load;
    logic [8:0]  c_ifm_buf_req_row;
    logic        o_dma_req;
    logic [8:0]  o_dma_row;
    logic        dma_valid;
    logic [31:0] dma_data;
    logic        o_dma_ready, o_ifm_buf_done, o_busy;
    logic        c_ctrl_data_run;
    logic [8:0]  c_row, c_col;
    logic [31:0] o_ib_data0, o_ib_data1, o_ib_data2;
    logic        o_ib_valid, o_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] img [16][16];
    logic [31:0] stage [16];
    bit          m_valid [3];
    int          m_tag [3];
    int          m_ptr;
    bit          m_err;

    always #5 clk = ~clk;

    ifm_row_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .q_width            (q_width),
        .q_height           (q_height),
        .q_start            (q_start),
        .c_ifm_buf_req_load (c_ifm_buf_req_load),
        .c_ifm_buf_req_row  (c_ifm_buf_req_row),
        .o_dma_req          (o_dma_req),
        .o_dma_row          (o_dma_row),
        .dma_valid          (dma_valid),
        .dma_data           (dma_data),
        .o_dma_ready        (o_dma_ready),
        .o_ifm_buf_done     (o_ifm_buf_done),
        .o_busy             (o_busy),
        .c_ctrl_data_run    (c_ctrl_data_run),
        .c_row              (c_row),
        .c_col              (c_col),
        .o_ib_data0         (o_ib_data0),
        .o_ib_data1         (o_ib_data1),
        .o_ib_data2         (o_ib_data2),
        .o_ib_valid         (o_ib_valid),
        .o_err              (o_err)
    );

    task automatic model_clear();
        for (int b = 0; b < 3; b++) begin
            m_valid[b] = 0;
            m_tag[b]   = -1;
        end
        m_ptr = 0;
        m_err = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        q_start = 1'b1;
        @(negedge clk);
        q_start = 1'b0;
        model_clear();
    endtask

    task automatic random_stage(input int w);
        for (int i = 0; i < w; i++)
            stage[i] = $urandom;
    endtask

    task automatic load_row(input int row, input int w, input bit extra);
        int i;
        int guard;
        @(negedge clk);
        c_ifm_buf_req_load = 1'b1;
        c_ifm_buf_req_row  = row[8:0];
        m_valid[m_ptr]     = 0;
        @(negedge clk);
        c_ifm_buf_req_load = 1'b0;
        n_cmp++;
        if (o_dma_req !== 1'b1 || o_dma_row !== row[8:0]) begin
            n_bad++;
            $display("FAIL dma_req row %0d: req=%b row=%0d, want req=1 row=%0d",
                     row, o_dma_req, o_dma_row, row);
        end
        i = 0;
        guard = 0;
        while (i < w && guard < 200) begin
            @(negedge clk);
            guard++;
            n_cmp++;
            if (o_dma_ready !== 1'b1 || o_ifm_buf_done !== 1'b0) begin
                n_bad++;
                $display("FAIL fill row %0d word %0d: ready=%b done=%b, want ready=1 done=0",
                         row, i, o_dma_ready, o_ifm_buf_done);
            end
            if (extra && i == 2) begin
                c_ifm_buf_req_load = 1'b1;
                c_ifm_buf_req_row  = 9'd9;
                m_err = 1;
            end else begin
                c_ifm_buf_req_load = 1'b0;
            end
            if ($urandom_range(3) == 0) begin
                dma_valid = 1'b0;
                dma_data  = $urandom;
            end else begin
                dma_valid = 1'b1;
                dma_data  = stage[i];
                i++;
            end
        end
        n_cmp++;
        if (i < w) begin
            n_bad++;
            $display("FAIL fill timeout row %0d: sent %0d words, want %0d", row, i, w);
        end
        @(negedge clk);
        dma_valid          = 1'b0;
        c_ifm_buf_req_load = 1'b0;
        n_cmp++;
        if (o_ifm_buf_done !== 1'b1 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL done pulse row %0d: done=%b busy=%b, want 1 1",
                     row, o_ifm_buf_done, o_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ifm_buf_done !== 1'b0 || o_busy !== 1'b0 || o_err !== m_err) begin
            n_bad++;
            $display("FAIL after done row %0d: done=%b busy=%b err=%b, want 0 0 %b",
                     row, o_ifm_buf_done, o_busy, o_err, m_err);
        end
        for (int k = 0; k < w; k++)
            img[row][k] = stage[k];
        m_tag[m_ptr]   = row;
        m_valid[m_ptr] = 1;
        m_ptr          = (m_ptr + 1) % 3;
    endtask

    // Back-to-back reads; row/col of -1 means random.
    task automatic read_burst(input int n, input int row, input int col);
        logic [31:0] e [3];
        bit          pend;
        int          r, c, rr;
        bit          found;
        pend = 0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (pend) begin
                n_cmp++;
                if (o_ib_valid !== 1'b1 || o_ib_data0 !== e[0] || o_ib_data1 !== e[1] ||
                    o_ib_data2 !== e[2] || o_err !== m_err) begin
                    n_bad++;
                    $display("FAIL read r%0d c%0d: v=%b d=%h %h %h err=%b, want v=1 d=%h %h %h err=%b",
                             r, c, o_ib_valid, o_ib_data0, o_ib_data1, o_ib_data2, o_err,
                             e[0], e[1], e[2], m_err);
                end
            end
            if (k < n) begin
                r = (row >= 0) ? row : $urandom_range(int'(q_height) - 1);
                c = (col >= 0) ? col : $urandom_range(int'(q_width) - 1);
                for (int j = 0; j < 3; j++) begin
                    rr = r - 1 + j;
                    e[j] = '0;
                    if (!((j == 0 && r == 0) || (j == 2 && r == int'(q_height) - 1))) begin
                        found = 0;
                        for (int b = 0; b < 3; b++)
                            if (m_valid[b] && m_tag[b] == rr) found = 1;
                        if (found) e[j] = img[rr][c];
                        else m_err = 1;
                    end
                end
                c_ctrl_data_run = 1'b1;
                c_row = r[8:0];
                c_col = c[8:0];
                pend = 1;
            end else begin
                c_ctrl_data_run = 1'b0;
                pend = 0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (o_ib_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL valid drop: o_ib_valid=%b, want 0", o_ib_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_cmp++;
        if ({o_dma_req, o_dma_ready, o_ifm_buf_done, o_busy, o_ib_valid, o_err} !== 6'b0 ||
            o_dma_row !== 9'd0 || o_ib_data0 !== 32'd0 || o_ib_data1 !== 32'd0 ||
            o_ib_data2 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: req=%b rdy=%b done=%b busy=%b v=%b err=%b row=%0d d=%h %h %h, want all 0",
                     o_dma_req, o_dma_ready, o_ifm_buf_done, o_busy, o_ib_valid, o_err,
                     o_dma_row, o_ib_data0, o_ib_data1, o_ib_data2);
        end
    endtask

    task automatic test_fill();
        q_width  = 9'd16;
        q_height = 9'd3;
        pulse_start();
        random_stage(16);
        stage[0] = 32'h00707064;
        load_row(0, 16, 0);
        random_stage(16);
        stage[0]  = 32'h00474644;
        stage[15] = 32'h003A3B39;
        load_row(1, 16, 0);
        random_stage(16);
        stage[15] = 32'h00404040;
        load_row(2, 16, 0);
    endtask

    task automatic test_read();
        read_burst(1, 0, 0);
        read_burst(1, 2, 15);
        read_burst(12, -1, -1);
    endtask

    task automatic test_discard();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_dma_ready !== 1'b0 || o_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle discard: ready=%b busy=%b, want 0 0", o_dma_ready, o_busy);
            end
            dma_valid = 1'b1;
            dma_data  = $urandom;
        end
        @(negedge clk);
        dma_valid = 1'b0;
        read_burst(6, -1, -1);
    endtask

    task automatic test_overwrite();
        random_stage(16);
        load_row(3, 16, 0);
        read_burst(4, 1, -1);
        read_burst(2, 2, -1);
    endtask

    task automatic test_double_load();
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL start clears err: err=%b, want 0", o_err);
        end
        random_stage(16);
        load_row(0, 16, 1);
        random_stage(16);
        load_row(1, 16, 0);
        random_stage(16);
        load_row(2, 16, 0);
        read_burst(8, -1, -1);
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        c_ifm_buf_req_load = 1'b1;
        c_ifm_buf_req_row  = 9'd0;
        @(negedge clk);
        c_ifm_buf_req_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dma_valid = 1'b1;
            dma_data  = $urandom;
        end
        @(negedge clk);
        dma_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_cmp++;
        if (o_busy !== 1'b0 || o_dma_ready !== 1'b0 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst mid fill: busy=%b ready=%b err=%b, want 0 0 0",
                     o_busy, o_dma_ready, o_err);
        end
        for (int r = 0; r < 3; r++) begin
            random_stage(16);
            load_row(r, 16, 0);
        end
        read_burst(10, -1, -1);
    endtask

    task automatic test_height1();
        q_height = 9'd1;
        pulse_start();
        random_stage(16);
        load_row(0, 16, 0);
        read_burst(6, 0, -1);
    endtask

    task automatic test_width0();
        q_width = 9'd0;
        pulse_start();
        @(negedge clk);
        c_ifm_buf_req_load = 1'b1;
        c_ifm_buf_req_row  = 9'd7;
        @(negedge clk);
        c_ifm_buf_req_load = 1'b0;
        dma_valid = 1'b1;
        n_cmp++;
        if (o_dma_req !== 1'b1 || o_dma_row !== 9'd7) begin
            n_bad++;
            $display("FAIL w0 req: req=%b row=%0d, want 1 7", o_dma_req, o_dma_row);
        end
        @(negedge clk);
        n_cmp++;
        if (o_ifm_buf_done !== 1'b1 || o_dma_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL w0 done: done=%b ready=%b, want 1 0", o_ifm_buf_done, o_dma_ready);
        end
        @(negedge clk);
        dma_valid = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL w0 idle: busy=%b err=%b, want 0 0", o_busy, o_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        q_width = 9'd16;
        q_height = 9'd3;
        q_start = 1'b0;
        c_ifm_buf_req_load = 1'b0;
        c_ifm_buf_req_row = '0;
        dma_valid = 1'b0;
        dma_data = '0;
        c_ctrl_data_run = 1'b0;
        c_row = '0;
        c_col = '0;
        test_reset();
        test_fill();
        test_read();
        test_discard();
        test_overwrite();
        test_double_load();
        test_reset_mid_fill();
        test_height1();
        test_width0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
